// File: rtl/storage_arbiter.sv
// storage_arbiter: arbitrates a management Wishbone port (read/write) and a
// user-project Wishbone port (read-only) onto two single-port SRAM macros.
// Every access takes four cycles: IDLE -> ACCESS -> CAPTURE -> DONE.
// The macro strobe is driven in ACCESS. Read data is registered in CAPTURE.
// The ack is registered out of DONE, so it is seen in the cycle after DONE.
// Optional build macro: STORAGE_ARB_FIXED_PRIO_EN. When it is defined, mgmt
// always wins a conflict. By default, conflicts are resolved round-robin.
module storage_arbiter (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mgmt_cyc_i,
  input  logic        mgmt_stb_i,
  input  logic        mgmt_we_i,
  input  logic [3:0]  mgmt_sel_i,
  input  logic [8:0]  mgmt_adr_i,
  input  logic [31:0] mgmt_dat_i,
  output logic        mgmt_ack_o,
  output logic [31:0] mgmt_dat_o,
  input  logic        user_cyc_i,
  input  logic        user_stb_i,
  input  logic [8:0]  user_adr_i,
  output logic        user_ack_o,
  output logic [31:0] user_dat_o,
  output logic        sram0_csb_o,
  output logic        sram1_csb_o,
  output logic        sram_web_o,
  output logic [3:0]  sram_wmask_o,
  output logic [7:0]  sram_addr_o,
  output logic [31:0] sram_din_o,
  input  logic [31:0] sram0_dout_i,
  input  logic [31:0] sram1_dout_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic        win_mgmt_q, win_mgmt_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [8:0]  adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        csb0_q, csb0_d, csb1_q, csb1_d;
  logic        web_q, web_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [7:0]  addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic        mgmt_ack_q, mgmt_ack_d, user_ack_q, user_ack_d;
  logic [31:0] mgmt_dat_q, mgmt_dat_d, user_dat_q, user_dat_d;

  logic        mgmt_vld, user_vld, grant_mgmt;
  logic [31:0] rdata;

  assign mgmt_vld = mgmt_cyc_i & mgmt_stb_i;
  assign user_vld = user_cyc_i & user_stb_i;
  assign rdata    = adr_q[8] ? sram1_dout_i : sram0_dout_i;

`ifdef STORAGE_ARB_FIXED_PRIO_EN
  // Fixed priority: mgmt wins whenever it requests.
  assign grant_mgmt = mgmt_vld;
`else
  logic last_mgmt_q, last_mgmt_d;

  // Round-robin: on a conflict, mgmt wins unless it won the previous grant.
  assign grant_mgmt = mgmt_vld & (~user_vld | ~last_mgmt_q);

  // Record the winner of each grant. The reset value means the user won last.
  always_comb begin
    last_mgmt_d = last_mgmt_q;
    if (state_q == IDLE && (mgmt_vld || user_vld)) last_mgmt_d = grant_mgmt;
  end

  // Grant history register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) last_mgmt_q <= 1'b0;
    else          last_mgmt_q <= last_mgmt_d;
  end
`endif

  // Next state, latched transaction fields, and registered bus/macro outputs.
  always_comb begin
    state_d    = state_q;
    win_mgmt_d = win_mgmt_q;
    we_d       = we_q;
    sel_d      = sel_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    addr_d     = addr_q;
    din_d      = din_q;
    csb0_d     = 1'b1;
    csb1_d     = 1'b1;
    web_d      = 1'b1;
    wmask_d    = 4'h0;
    mgmt_ack_d = 1'b0;
    user_ack_d = 1'b0;
    mgmt_dat_d = mgmt_dat_q;
    user_dat_d = user_dat_q;
    case (state_q)
      IDLE: begin
        if (mgmt_vld || user_vld) begin
          win_mgmt_d = grant_mgmt;
          we_d       = grant_mgmt & mgmt_we_i;
          sel_d      = grant_mgmt ? mgmt_sel_i : 4'h0;
          adr_d      = grant_mgmt ? mgmt_adr_i : user_adr_i;
          dat_d      = grant_mgmt ? mgmt_dat_i : 32'h0;
          state_d    = ACCESS;
        end
      end
      ACCESS:  state_d = CAPTURE;
      CAPTURE: begin
        state_d = DONE;
        if (!we_q) begin
          if (win_mgmt_q) mgmt_dat_d = rdata;
          else            user_dat_d = rdata;
        end
      end
      DONE: begin
        state_d    = IDLE;
        mgmt_ack_d = win_mgmt_q;
        user_ack_d = ~win_mgmt_q;
      end
      default: state_d = IDLE;
    endcase
    // The macro pins are registered, so they are loaded on entry to ACCESS.
    if (state_d == ACCESS) begin
      csb0_d  = adr_d[8];
      csb1_d  = ~adr_d[8];
      web_d   = ~we_d;
      wmask_d = sel_d;
      addr_d  = adr_d[7:0];
      din_d   = dat_d;
    end
  end

  // FSM and registered outputs. Reset aborts any transaction in flight.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      win_mgmt_q <= 1'b0;
      we_q       <= 1'b0;
      sel_q      <= 4'h0;
      adr_q      <= 9'h0;
      dat_q      <= 32'h0;
      csb0_q     <= 1'b1;
      csb1_q     <= 1'b1;
      web_q      <= 1'b1;
      wmask_q    <= 4'h0;
      addr_q     <= 8'h0;
      din_q      <= 32'h0;
      mgmt_ack_q <= 1'b0;
      user_ack_q <= 1'b0;
      mgmt_dat_q <= 32'h0;
      user_dat_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      win_mgmt_q <= win_mgmt_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      csb0_q     <= csb0_d;
      csb1_q     <= csb1_d;
      web_q      <= web_d;
      wmask_q    <= wmask_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      mgmt_ack_q <= mgmt_ack_d;
      user_ack_q <= user_ack_d;
      mgmt_dat_q <= mgmt_dat_d;
      user_dat_q <= user_dat_d;
    end
  end

  assign mgmt_ack_o   = mgmt_ack_q;
  assign user_ack_o   = user_ack_q;
  assign mgmt_dat_o   = mgmt_dat_q;
  assign user_dat_o   = user_dat_q;
  assign sram0_csb_o  = csb0_q;
  assign sram1_csb_o  = csb1_q;
  assign sram_web_o   = web_q;
  assign sram_wmask_o = wmask_q;
  assign sram_addr_o  = addr_q;
  assign sram_din_o   = din_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_storage_arbiter.sv
// Self-checking bench for storage_arbiter. It contains behavioural SRAM macros
// and a transaction-level reference model: golden memories, an arbitration
// rule, and the expected read-data registers.
module tb_storage_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        mgmt_cyc_i, mgmt_stb_i, mgmt_we_i;
  logic [3:0]  mgmt_sel_i;
  logic [8:0]  mgmt_adr_i;
  logic [31:0] mgmt_dat_i;
  logic        mgmt_ack_o;
  logic [31:0] mgmt_dat_o;
  logic        user_cyc_i, user_stb_i;
  logic [8:0]  user_adr_i;
  logic        user_ack_o;
  logic [31:0] user_dat_o;
  logic        sram0_csb_o, sram1_csb_o, sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_din_o;
  logic [31:0] sram0_dout_i, sram1_dout_i;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem0 [256] = '{default: 32'h0};
  logic [31:0] mem1 [256] = '{default: 32'h0};
  logic [31:0] gold0 [256];
  logic [31:0] gold1 [256];
  logic [31:0] exp_mgmt_dat, exp_user_dat;
  bit          last_mgmt;
  bit          obs_mgmt_ack;
  logic [31:0] obs_dat;

  storage_arbiter dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .mgmt_cyc_i(mgmt_cyc_i), .mgmt_stb_i(mgmt_stb_i), .mgmt_we_i(mgmt_we_i),
    .mgmt_sel_i(mgmt_sel_i), .mgmt_adr_i(mgmt_adr_i), .mgmt_dat_i(mgmt_dat_i),
    .mgmt_ack_o(mgmt_ack_o), .mgmt_dat_o(mgmt_dat_o),
    .user_cyc_i(user_cyc_i), .user_stb_i(user_stb_i), .user_adr_i(user_adr_i),
    .user_ack_o(user_ack_o), .user_dat_o(user_dat_o),
    .sram0_csb_o(sram0_csb_o), .sram1_csb_o(sram1_csb_o), .sram_web_o(sram_web_o),
    .sram_wmask_o(sram_wmask_o), .sram_addr_o(sram_addr_o), .sram_din_o(sram_din_o),
    .sram0_dout_i(sram0_dout_i), .sram1_dout_i(sram1_dout_i),
    .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural SRAM macros: a strobe at an edge makes read data valid in the next cycle.
  always @(posedge wb_clk_i) begin
    logic [31:0] w;
    if (!sram0_csb_o) begin
      if (!sram_web_o) begin
        w = mem0[sram_addr_o];
        for (int b = 0; b < 4; b++) if (sram_wmask_o[b]) w[b*8 +: 8] = sram_din_o[b*8 +: 8];
        mem0[sram_addr_o] <= w;
      end else sram0_dout_i <= mem0[sram_addr_o];
    end
    if (!sram1_csb_o) begin
      if (!sram_web_o) begin
        w = mem1[sram_addr_o];
        for (int b = 0; b < 4; b++) if (sram_wmask_o[b]) w[b*8 +: 8] = sram_din_o[b*8 +: 8];
        mem1[sram_addr_o] <= w;
      end else sram1_dout_i <= mem1[sram_addr_o];
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit model_pick_mgmt(input bit m, input bit u);
    if (m && !u) return 1'b1;
    if (u && !m) return 1'b0;
`ifdef STORAGE_ARB_FIXED_PRIO_EN
    return 1'b1;
`else
    return !last_mgmt;
`endif
  endfunction

  task automatic model_reset();
    last_mgmt    = 1'b0;
    exp_mgmt_dat = 32'h0;
    exp_user_dat = 32'h0;
  endtask

  task automatic idle_inputs();
    mgmt_cyc_i = 0; mgmt_stb_i = 0; mgmt_we_i = 0; mgmt_sel_i = 0;
    mgmt_adr_i = 0; mgmt_dat_i = 0;
    user_cyc_i = 0; user_stb_i = 0; user_adr_i = 0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    model_reset();
  endtask

  // Issue one arbitration round and check it cycle by cycle. The task is
  // called at a negedge while the DUT is idle, and it returns on the negedge
  // where the ack is visible. drop: 0 = keep the requests high, 1 = drop
  // cyc and stb after the grant, 2 = drop only stb after the grant.
  task automatic txn(input string tag, input bit m_req, input bit u_req,
                     input logic [8:0] m_adr, input logic [8:0] u_adr,
                     input bit m_we, input logic [3:0] m_sel,
                     input logic [31:0] m_wdat, input int drop);
    bit win, we;
    logic [8:0] adr;
    logic [31:0] m, old, nw;
    int lo0, lo1;
    mgmt_cyc_i = m_req; mgmt_stb_i = m_req; mgmt_we_i = m_we;
    mgmt_sel_i = m_sel; mgmt_adr_i = m_adr; mgmt_dat_i = m_wdat;
    user_cyc_i = u_req; user_stb_i = u_req; user_adr_i = u_adr;
    win = model_pick_mgmt(m_req, u_req);
    last_mgmt = win;
    adr = win ? m_adr : u_adr;
    we  = win && m_we;
    old = adr[8] ? gold1[adr[7:0]] : gold0[adr[7:0]];
    if (we) begin
      m  = {{8{m_sel[3]}}, {8{m_sel[2]}}, {8{m_sel[1]}}, {8{m_sel[0]}}};
      nw = (old & ~m) | (m_wdat & m);
      if (adr[8]) gold1[adr[7:0]] = nw; else gold0[adr[7:0]] = nw;
    end else if (win) exp_mgmt_dat = old;
    else exp_user_dat = old;
    @(posedge wb_clk_i); #1;
    if (drop == 1) begin
      mgmt_cyc_i = 0; mgmt_stb_i = 0; user_cyc_i = 0; user_stb_i = 0;
    end else if (drop == 2) begin
      mgmt_stb_i = 0; user_stb_i = 0;
    end
    lo0 = 0; lo1 = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge wb_clk_i);
      if (!sram0_csb_o) lo0++;
      if (!sram1_csb_o) lo1++;
      if (k == 0) begin
        checks++;
        if (sram_web_o !== (we ? 1'b0 : 1'b1))
          begin errors++; $display("FAIL %s web: got %0b want %0b", tag, sram_web_o, !we); end
        if (win) begin
          checks++;
          if (sram_wmask_o !== m_sel)
            begin errors++; $display("FAIL %s wmask: got %h want %h", tag, sram_wmask_o, m_sel); end
        end
        checks++;
        if (sram_addr_o !== adr[7:0])
          begin errors++; $display("FAIL %s addr: got %h want %h", tag, sram_addr_o, adr[7:0]); end
        if (we) begin
          checks++;
          if (sram_din_o !== m_wdat)
            begin errors++; $display("FAIL %s din: got %h want %h", tag, sram_din_o, m_wdat); end
        end
      end else if (k < 3) begin
        checks++;
        if ({sram0_csb_o, sram1_csb_o, sram_web_o, sram_wmask_o} !== 7'b1110000)
          begin errors++; $display("FAIL %s idle_pins k=%0d: got %b want 1110000", tag, k,
                                   {sram0_csb_o, sram1_csb_o, sram_web_o, sram_wmask_o}); end
      end
      if (k < 3) begin
        checks++;
        if ({mgmt_ack_o, user_ack_o, busy_o} !== 3'b001)
          begin errors++; $display("FAIL %s early k=%0d: ack/ack/busy got %b want 001", tag, k,
                                   {mgmt_ack_o, user_ack_o, busy_o}); end
      end
    end
    checks++;
    if (lo0 !== (adr[8] ? 0 : 1) || lo1 !== (adr[8] ? 1 : 0))
      begin errors++; $display("FAIL %s strobes: got csb0=%0d csb1=%0d want %0d %0d", tag, lo0, lo1,
                               adr[8] ? 0 : 1, adr[8] ? 1 : 0); end
    checks++;
    if ({mgmt_ack_o, user_ack_o, busy_o} !== {win, !win, 1'b0})
      begin errors++; $display("FAIL %s ack: mgmt/user/busy got %b want %b", tag,
                               {mgmt_ack_o, user_ack_o, busy_o}, {win, !win, 1'b0}); end
    checks++;
    if (mgmt_dat_o !== exp_mgmt_dat)
      begin errors++; $display("FAIL %s mgmt_dat: got %h want %h", tag, mgmt_dat_o, exp_mgmt_dat); end
    checks++;
    if (user_dat_o !== exp_user_dat)
      begin errors++; $display("FAIL %s user_dat: got %h want %h", tag, user_dat_o, exp_user_dat); end
    obs_mgmt_ack = mgmt_ack_o;
    obs_dat      = win ? mgmt_dat_o : user_dat_o;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checks++;
    if ({mgmt_ack_o, user_ack_o, sram0_csb_o, sram1_csb_o, sram_web_o, sram_wmask_o, busy_o} !== 10'b0011100000)
      begin errors++; $display("FAIL reset_ctrl: got %b want 0011100000",
             {mgmt_ack_o, user_ack_o, sram0_csb_o, sram1_csb_o, sram_web_o, sram_wmask_o, busy_o}); end
    checks++;
    if ({mgmt_dat_o, user_dat_o, sram_din_o, sram_addr_o} !== 104'h0)
      begin errors++; $display("FAIL reset_data: got %h %h %h %h want all zero",
                               mgmt_dat_o, user_dat_o, sram_din_o, sram_addr_o); end
    wb_rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_write_read();
    txn("wr003", 1, 0, 9'h003, 9'h0, 1, 4'hF, 32'hA5A5_5A5A, 1);
    txn("rd003", 1, 0, 9'h003, 9'h0, 0, 4'hF, 32'h0, 1);
    checks++;
    if (obs_dat !== 32'hA5A5_5A5A)
      begin errors++; $display("FAIL readback003: got %h want a5a55a5a", obs_dat); end
  endtask

  task automatic test_partial_write();
    txn("fill1ff", 1, 0, 9'h1FF, 9'h0, 1, 4'hF, 32'hFFFF_FFFF, 1);
    txn("wr1ff", 1, 0, 9'h1FF, 9'h0, 1, 4'h3, 32'h1234_5678, 1);
    txn("rd1ff", 1, 0, 9'h1FF, 9'h0, 0, 4'hF, 32'h0, 1);
    checks++;
    if (obs_dat !== 32'hFFFF_5678)
      begin errors++; $display("FAIL readback1ff: got %h want ffff5678", obs_dat); end
  endtask

  task automatic test_arbitration();
    bit exp_seq [3];
    do_reset();
`ifdef STORAGE_ARB_FIXED_PRIO_EN
    exp_seq = '{1'b1, 1'b1, 1'b1};
`else
    exp_seq = '{1'b1, 1'b0, 1'b1};
`endif
    for (int g = 0; g < 3; g++) begin
      txn("conflict", 1, 1, 9'h010, 9'h010, 0, 4'hF, 32'h0, (g == 2) ? 1 : 0);
      checks++;
      if (obs_mgmt_ack !== exp_seq[g])
        begin errors++; $display("FAIL grant_order[%0d]: mgmt_won got %0b want %0b", g, obs_mgmt_ack, exp_seq[g]); end
    end
    txn("user_alone", 0, 1, 9'h0, 9'h010, 0, 4'h0, 32'h0, 1);
  endtask

  task automatic test_cyc_low();
    bit bad;
    bad = 0;
    user_cyc_i = 0; user_stb_i = 1; user_adr_i = 9'h020;
    for (int c = 0; c < 6; c++) begin
      @(negedge wb_clk_i);
      if (!sram0_csb_o || !sram1_csb_o || user_ack_o || busy_o) bad = 1;
    end
    checks++;
    if (bad !== 1'b0)
      begin errors++; $display("FAIL cyc_low: activity got %0b want 0", bad); end
    user_stb_i = 0;
  endtask

  task automatic test_reset_mid();
    mgmt_cyc_i = 1; mgmt_stb_i = 1; mgmt_we_i = 0; mgmt_sel_i = 4'hF; mgmt_adr_i = 9'h003;
    @(posedge wb_clk_i); #1;
    idle_inputs();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    checks++;
    if ({mgmt_ack_o, sram0_csb_o, sram1_csb_o, sram_web_o, sram_wmask_o, busy_o} !== 9'b011100000)
      begin errors++; $display("FAIL rst_mid_ctrl: got %b want 011100000",
             {mgmt_ack_o, sram0_csb_o, sram1_csb_o, sram_web_o, sram_wmask_o, busy_o}); end
    checks++;
    if ({mgmt_dat_o, sram_addr_o, sram_din_o} !== 72'h0)
      begin errors++; $display("FAIL rst_mid_data: got %h %h %h want zero", mgmt_dat_o, sram_addr_o, sram_din_o); end
    wb_rst_i = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge wb_clk_i);
      checks++;
      if ({mgmt_ack_o, user_ack_o} !== 2'b00)
        begin errors++; $display("FAIL rst_mid_noack c=%0d: got %b want 00", c, {mgmt_ack_o, user_ack_o}); end
    end
    txn("after_rst", 1, 0, 9'h003, 9'h0, 0, 4'hF, 32'h0, 1);
  endtask

  task automatic test_stb_drop();
    txn("stb_drop", 1, 0, 9'h0A5, 9'h0, 0, 4'h5, 32'h0, 2);
    @(negedge wb_clk_i);
    checks++;
    if ({mgmt_ack_o, busy_o} !== 2'b00)
      begin errors++; $display("FAIL stb_drop_once: ack/busy got %b want 00", {mgmt_ack_o, busy_o}); end
    mgmt_cyc_i = 0;
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(1, 3);
      txn("random", r[0], r[1], 9'($urandom), 9'($urandom), 1'($urandom),
          4'($urandom_range(1, 15)), $urandom, 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin gold0[i] = 32'h0; gold1[i] = 32'h0; end
    wb_rst_i = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_write_read();
    test_partial_write();
    test_arbitration();
    test_cyc_low();
    test_reset_mid();
    test_stb_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
